// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: ALU op codes, forward selects,
// result-source encodings and the EX-stage pipeline register layouts.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_XOR  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alucontrol;
        logic            alusrc;
        logic            regwrite;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      resultsrc;
        logic [2:0]      funct3;
    } idex_t;

    typedef struct packed {
        logic [XLEN-1:0] aluresult;
        logic [XLEN-1:0] writedata;
        logic [XLEN-1:0] pcplus4;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic [1:0]      resultsrc;
    } exmem_t;

    // Select code 11 is unused by the hazard unit and falls back to the regfile.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] wb,
                                                input logic [XLEN-1:0] mem);
        case (sel)
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rf;
        endcase
    endfunction
endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU driven by the 4-bit alucontrol code from decode.
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic [3:0]      alucontrol,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    logic [4:0] shamt;
    assign shamt = srcb[4:0];

    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_ADD:  result = srca + srcb;
            ALU_SUB:  result = srca - srcb;
            ALU_AND:  result = srca & srcb;
            ALU_OR:   result = srca | srcb;
            ALU_XOR:  result = srca ^ srcb;
            ALU_SLL:  result = srca << shamt;
            ALU_SRL:  result = srca >> shamt;
            ALU_SRA:  result = $unsigned($signed(srca) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (srca < srcb)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/execute_stage.sv
// EX stage: ID/EX register, forwarding muxes, ALU, branch/jump resolution
// and the EX/MEM register.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_pcplus4,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alucontrol,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic            id_jalr,
    input  logic [1:0]      id_resultsrc,
    input  logic [2:0]      id_funct3,
    input  logic            ex_stall,
    input  logic            ex_flush,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] mem_aluresult,
    input  logic [XLEN-1:0] wb_result,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_resultsrc0,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] m_aluresult,
    output logic [XLEN-1:0] m_writedata,
    output logic [XLEN-1:0] m_pcplus4,
    output logic [4:0]      m_rd,
    output logic            m_regwrite,
    output logic            m_memwrite,
    output logic [1:0]      m_resultsrc
);
    import riscv_pkg::*;

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;

    logic [XLEN-1:0] srca, writedata, srcb, aluresult, jalr_sum;
    logic            zero, taken, issue;

    always_comb begin
        idex_d = idex_q;
        if (ex_flush) begin
            idex_d = '0;
        end else if (!ex_stall) begin
            idex_d.valid      = id_valid;
            idex_d.rd1        = id_rd1;
            idex_d.rd2        = id_rd2;
            idex_d.imm        = id_imm;
            idex_d.pc         = id_pc;
            idex_d.pcplus4    = id_pcplus4;
            idex_d.rs1        = id_rs1;
            idex_d.rs2        = id_rs2;
            idex_d.rd         = id_rd;
            idex_d.alucontrol = id_alucontrol;
            idex_d.alusrc     = id_alusrc;
            idex_d.regwrite   = id_regwrite & id_valid;
            idex_d.memwrite   = id_memwrite & id_valid;
            idex_d.branch     = id_branch & id_valid;
            idex_d.jump       = id_jump & id_valid;
            idex_d.jalr       = id_jalr & id_valid;
            idex_d.resultsrc  = id_resultsrc & {2{id_valid}};
            idex_d.funct3     = id_funct3;
        end
    end

    assign srca      = fwd_mux(fwd_a, idex_q.rd1, wb_result, mem_aluresult);
    assign writedata = fwd_mux(fwd_b, idex_q.rd2, wb_result, mem_aluresult);
    assign srcb      = idex_q.alusrc ? idex_q.imm : writedata;

    alu u_alu (
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (idex_q.alucontrol),
        .result     (aluresult),
        .zero       (zero)
    );

    // funct3[0] distinguishes BEQ from BNE; the ALU performs SUB for both.
    assign taken     = idex_q.branch & (idex_q.funct3[0] ? ~zero : zero);
    assign pc_src    = idex_q.valid & ~ex_stall & (idex_q.jump | taken);
    assign jalr_sum  = srca + idex_q.imm;
    assign pc_target = idex_q.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (idex_q.pc + idex_q.imm);

    // A stalled instruction stays in ID/EX, so only its final cycle may issue.
    assign issue = idex_q.valid & ~ex_stall;

    always_comb begin
        exmem_d           = '0;
        exmem_d.aluresult = aluresult;
        exmem_d.writedata = writedata;
        exmem_d.pcplus4   = idex_q.pcplus4;
        exmem_d.rd        = idex_q.rd;
        exmem_d.regwrite  = idex_q.regwrite & issue;
        exmem_d.memwrite  = idex_q.memwrite & issue;
        exmem_d.resultsrc = idex_q.resultsrc & {2{issue}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    logic unused_funct3;
    assign unused_funct3 = ^idex_q.funct3[2:1];

    assign ex_rs1        = idex_q.rs1;
    assign ex_rs2        = idex_q.rs2;
    assign ex_rd         = idex_q.rd;
    assign ex_resultsrc0 = idex_q.resultsrc[0];
    assign m_aluresult   = exmem_q.aluresult;
    assign m_writedata   = exmem_q.writedata;
    assign m_pcplus4     = exmem_q.pcplus4;
    assign m_rd          = exmem_q.rd;
    assign m_regwrite    = exmem_q.regwrite;
    assign m_memwrite    = exmem_q.memwrite;
    assign m_resultsrc   = exmem_q.resultsrc;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table of single-instruction vectors
// checked through a scoreboard, plus stall/flush/valid/reset sequences.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc, id_pcplus4;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alucontrol;
    logic        id_alusrc, id_regwrite, id_memwrite, id_branch, id_jump, id_jalr;
    logic [1:0]  id_resultsrc;
    logic [2:0]  id_funct3;
    logic        ex_stall, ex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] mem_aluresult, wb_result;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_resultsrc0, pc_src;
    logic [31:0] pc_target, m_aluresult, m_writedata, m_pcplus4;
    logic [4:0]  m_rd;
    logic        m_regwrite, m_memwrite;
    logic [1:0]  m_resultsrc;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_pc(id_pc), .id_pcplus4(id_pcplus4),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jump(id_jump), .id_jalr(id_jalr),
        .id_resultsrc(id_resultsrc), .id_funct3(id_funct3),
        .ex_stall(ex_stall), .ex_flush(ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_aluresult(mem_aluresult), .wb_result(wb_result),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_resultsrc0(ex_resultsrc0), .pc_src(pc_src), .pc_target(pc_target),
        .m_aluresult(m_aluresult), .m_writedata(m_writedata), .m_pcplus4(m_pcplus4),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_memwrite(m_memwrite),
        .m_resultsrc(m_resultsrc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic        alusrc, branch, jump, jalr;
        logic [2:0]  f3;
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, imm, pc, mem, wb;
        logic [31:0] exp_alu;
        logic        exp_pcsrc;
        logic [31:0] exp_target;
    } vec_t;

    typedef struct packed {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
    } exp_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v, input logic [4:0] rd, input logic valid,
                         input logic rw, input logic mw);
        id_valid = valid; id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm;
        id_pc = v.pc; id_pcplus4 = v.pc + 32'd4;
        id_rs1 = rd + 5'd1; id_rs2 = rd + 5'd2; id_rd = rd;
        id_alucontrol = v.ctl; id_alusrc = v.alusrc;
        id_regwrite = rw; id_memwrite = mw; id_branch = v.branch;
        id_jump = v.jump; id_jalr = v.jalr; id_resultsrc = 2'b00; id_funct3 = v.f3;
        fwd_a = v.fa; fwd_b = v.fb; mem_aluresult = v.mem; wb_result = v.wb;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ex_rd"}, {27'b0, ex_rd}, 32'd0);
        chk({tag, "_pc_src"}, {31'b0, pc_src}, 32'd0);
        chk({tag, "_pc_target"}, pc_target, 32'd0);
        chk({tag, "_m_alu"}, m_aluresult, 32'd0);
        chk({tag, "_m_wd"}, m_writedata, 32'd0);
        chk({tag, "_m_pc4"}, m_pcplus4, 32'd0);
        chk({tag, "_m_ctl"}, {25'b0, m_rd, m_regwrite, m_memwrite}, 32'd0);
    endtask

    vec_t nop_v, jv;
    exp_t e;
    logic [31:0] wd_model;

    initial begin
        //            ctl    as    br    j     jr    f3     fa     fb     rd1           rd2           imm           pc            mem           wb            alu           ps    target
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0,        32'd0,        32'd0,        32'd0,        32'd8,        1'b0, 32'd0};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0,        32'd0,        32'd0,        32'd0,        32'd2,        1'b0, 32'd0};
        vecs[2]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd0,        32'd1,        32'd0,        32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 32'd0};
        vecs[3]  = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h80000000, 32'd0,        32'd4,        32'd0,        32'd0,        32'd0,        32'hF8000000, 1'b0, 32'd4};
        vecs[4]  = '{4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h80000000, 32'd0,        32'd4,        32'd0,        32'd0,        32'd0,        32'h08000000, 1'b0, 32'd4};
        vecs[5]  = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h80000000, 32'd1,        32'd0,        32'd0,        32'd0,        32'd0,        32'd1,        1'b0, 32'd0};
        vecs[6]  = '{4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h80000000, 32'd1,        32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 32'd0};
        vecs[7]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 32'd0,        32'h20,       32'd0,        32'd0,        32'h10,       32'd0,        32'h30,       1'b0, 32'd0};
        vecs[8]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd0, 32'd0,        32'h20,       32'd0,        32'd0,        32'h10,       32'd7,        32'h27,       1'b0, 32'd0};
        vecs[9]  = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd9,        32'd9,        32'h20,       32'h100,      32'd0,        32'd0,        32'd0,        1'b1, 32'h120};
        vecs[10] = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd9,        32'd8,        32'h20,       32'h100,      32'd0,        32'd0,        32'd1,        1'b0, 32'h120};
        vecs[11] = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd0, 2'd0, 32'd9,        32'd9,        32'h20,       32'h100,      32'd0,        32'd0,        32'd0,        1'b0, 32'h120};
        vecs[12] = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd0, 2'd0, 32'd9,        32'd8,        32'h20,       32'h100,      32'd0,        32'd0,        32'd1,        1'b1, 32'h120};
        vecs[13] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 2'd0, 32'h203,      32'd0,        32'd0,        32'h300,      32'd0,        32'd0,        32'h203,      1'b1, 32'h202};
        vecs[14] = '{4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,        32'd0,        32'd0,        32'h0FF00FF0, 1'b0, 32'd0};
        vecs[15] = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,        32'd0,        32'd0,        32'hF000F000, 1'b0, 32'd0};
        vecs[16] = '{4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,        32'd0,        32'd0,        32'hFFF0FFF0, 1'b0, 32'd0};
        vecs[17] = '{4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd1,        32'd0,        32'd31,       32'd0,        32'd0,        32'd0,        32'h80000000, 1'b0, 32'h1F};
        vecs[18] = '{4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h80000000, 32'h24,       32'd0,        32'd0,        32'd0,        32'd0,        32'h08000000, 1'b0, 32'd0};
        vecs[19] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 32'd0};
        vecs[20] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd2, 32'd1,        32'd99,       32'd0,        32'd0,        32'h40,       32'd0,        32'h41,       1'b0, 32'd0};
        vecs[21] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd3, 2'd3, 32'h11,       32'd0,        32'd0,        32'd0,        32'd8,        32'd7,        32'h11,       1'b0, 32'd0};
        vecs[22] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 32'd0,        32'd0,        32'h20,       32'hFFFFFFF0, 32'd0,        32'd0,        32'd0,        1'b1, 32'h10};
        vecs[23] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 32'd0};
        vecs[24] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 2'd2, 2'd0, 32'd0,        32'd0,        32'h10,       32'h500,      32'h305,      32'd0,        32'h315,      1'b1, 32'h314};
        nop_v = '0;

        rst = 1'b1; ex_stall = 1'b0; ex_flush = 1'b0;
        drive(nop_v, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i], 5'(i + 1), 1'b1, 1'b1, 1'b0);
            wd_model = (vecs[i].fb == 2'd1) ? vecs[i].wb :
                       (vecs[i].fb == 2'd2) ? vecs[i].mem : vecs[i].rd2;
            sb.push_back('{vecs[i].exp_alu, wd_model, vecs[i].pc + 32'd4, 5'(i + 1)});
            @(posedge clk); #1;
            chk($sformatf("v%0d_pc_src", i), {31'b0, pc_src}, {31'b0, vecs[i].exp_pcsrc});
            chk($sformatf("v%0d_pc_target", i), pc_target, vecs[i].exp_target);
            @(negedge clk) id_valid = 1'b0;
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_m_alu", i), m_aluresult, e.alu);
                chk($sformatf("v%0d_m_wd", i), m_writedata, e.wd);
                chk($sformatf("v%0d_m_pc4", i), m_pcplus4, e.pc4);
                chk($sformatf("v%0d_m_rd", i), {27'b0, m_rd}, {27'b0, e.rd});
                chk($sformatf("v%0d_m_regwrite", i), {31'b0, m_regwrite}, 32'd1);
            end
            $display("vec %0d: alu=%h wd=%h pc_src=%0d target=%h", i, m_aluresult, m_writedata, pc_src, pc_target);
        end

        // Stall a jump for two cycles: held in ID/EX, no redirect, no issue.
        jv = '0; jv.jump = 1'b1; jv.pc = 32'h40; jv.imm = 32'h8;
        @(negedge clk) drive(jv, 5'd7, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk) begin ex_stall = 1'b1; id_rd = 5'd12; end
        #1 chk("stall_pc_src_0", {31'b0, pc_src}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_ex_rd", c), {27'b0, ex_rd}, 32'd7);
            chk($sformatf("stall%0d_m_regwrite", c), {31'b0, m_regwrite}, 32'd0);
            chk($sformatf("stall%0d_pc_src", c), {31'b0, pc_src}, 32'd0);
        end
        @(negedge clk) begin ex_stall = 1'b0; id_valid = 1'b0; end
        #1 chk("unstall_pc_src", {31'b0, pc_src}, 32'd1);
        chk("unstall_pc_target", pc_target, 32'h48);
        @(posedge clk); #1;
        chk("unstall_m_regwrite", {31'b0, m_regwrite}, 32'd1);
        chk("unstall_m_rd", {27'b0, m_rd}, 32'd7);
        $display("seq stall: ex_rd=%0d m_rd=%0d m_regwrite=%0d", ex_rd, m_rd, m_regwrite);

        // Flush together with stall: bubble wins over hold.
        @(negedge clk) begin
            drive(vecs[0], 5'd9, 1'b1, 1'b1, 1'b1);
            ex_flush = 1'b1; ex_stall = 1'b1;
        end
        @(posedge clk); #1;
        chk("flush_ex_rd", {27'b0, ex_rd}, 32'd0);
        @(negedge clk) begin ex_flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b0; end
        @(posedge clk); #1;
        chk("flush_m_regwrite", {31'b0, m_regwrite}, 32'd0);
        chk("flush_m_memwrite", {31'b0, m_memwrite}, 32'd0);
        $display("seq flush: m_regwrite=%0d m_memwrite=%0d", m_regwrite, m_memwrite);

        // Invalid decode slot with control bits set must not write.
        @(negedge clk) drive(vecs[0], 5'd10, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("invalid_m_regwrite", {31'b0, m_regwrite}, 32'd0);
        chk("invalid_m_memwrite", {31'b0, m_memwrite}, 32'd0);
        $display("seq invalid: m_regwrite=%0d m_memwrite=%0d", m_regwrite, m_memwrite);

        // Reset with a redirect pending clears everything in one edge.
        @(negedge clk) drive(jv, 5'd5, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("prereset_pc_src", {31'b0, pc_src}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        $display("seq reset: pc_src=%0d m_rd=%0d", pc_src, m_rd);
        @(negedge clk) rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
